seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Restoring sequential divider: one trial subtraction per cycle, MSB first.
// Divide-by-zero short-circuits to DONE with quotient all ones and remainder = dividend.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   p_next;
  logic             qbit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    shifted = {p_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    qbit    = ~trial[WIDTH];
    p_next  = qbit ? trial : shifted;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d = dividend;
          dvs_d = divisor;
          p_d   = '0;
          cnt_d = CW'(WIDTH);
          dbz_d = 1'b0;
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // dvd_q doubles as the quotient shift register as dividend bits drain out
        p_d   = p_next;
        dvd_d = {dvd_q[WIDTH-2:0], qbit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d   = {dvd_q[WIDTH-2:0], qbit};
          rem_d   = p_next[WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
